// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and decode handshake signals of the fetch stage
interface fetch_unit_if;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid_out;
    logic        if_ready_in;
    logic [31:0] if_pc_out;
    logic [31:0] if_instr_out;

    modport master (
        input  redirect_valid_in, redirect_pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready_in,
        output imem_req_valid, imem_req_addr, if_valid_out, if_pc_out, if_instr_out
    );

    modport slave (
        output redirect_valid_in, redirect_pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready_in,
        input  imem_req_valid, imem_req_addr, if_valid_out, if_pc_out, if_instr_out
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem reads and buffers returned instructions for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {RUN, DRAIN, STALL} state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q, rsp_pc_q;
    logic [CW-1:0] out_q, drop_q, out_d, drop_d;
    logic [FW-1:0] cnt_q;
    logic [PW-1:0] wr_q, rd_q;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic          redir, rsp, credit, req, hs, push, pop;

    // Credit, handshake and counter next-state; a redirect-cycle response is never live
    always_comb begin
        redir  = bus.redirect_valid_in;
        rsp    = bus.imem_rsp_valid;
        credit = int'(out_q - drop_q) + int'(cnt_q) < FIFO_DEPTH && int'(out_q) < MAX_OUTSTANDING;
        req    = credit && !redir && !reset;
        hs     = req && bus.imem_req_ready;
        push   = rsp && drop_q == '0 && !redir;
        pop    = cnt_q != '0 && bus.if_ready_in && !redir;
        out_d  = out_q + CW'(hs) - CW'(rsp);
        drop_d = redir ? out_q - CW'(rsp) : drop_q - CW'(rsp && drop_q != '0);
    end

    assign bus.imem_req_valid = req;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.if_valid_out   = cnt_q != '0;
    assign bus.if_pc_out      = mem_q[rd_q][63:32];
    assign bus.if_instr_out   = mem_q[rd_q][31:0];

    // PCs, in-flight counters, instruction buffer and status state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            out_q  <= out_d;
            drop_q <= drop_d;
            if (redir) begin
                fetch_pc_q <= bus.redirect_pc_in & ~32'd3;
                rsp_pc_q   <= bus.redirect_pc_in & ~32'd3;
                cnt_q      <= '0;
                wr_q       <= '0;
                rd_q       <= '0;
            end else begin
                if (hs) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (push) begin
                    mem_q[wr_q] <= {rsp_pc_q, bus.imem_rsp_data};
                    wr_q        <= wr_q + 1'b1;
                    rsp_pc_q    <= rsp_pc_q + 32'd4;
                end
                if (pop) rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + FW'(push) - FW'(pop);
            end
            case (state_q)
                RUN:     state_q <= (redir && out_d != '0) ? DRAIN : (credit ? RUN : STALL);
                STALL:   state_q <= (redir && out_d != '0) ? DRAIN : (credit ? RUN : STALL);
                default: state_q <= drop_d == '0 ? RUN : DRAIN;
            endcase
        end
    end

    // The credit rule must keep every accepted response within buffer capacity
    assert property (@(posedge clk) disable iff (reset) !(push && int'(cnt_q) == FIFO_DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with an in-order memory model and an expected-instruction scoreboard
module tb_fetch_unit;
    localparam int FIFO_DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    req_t        pending[$];
    logic [63:0] expq[$];
    logic [31:0] exp_fetch = 32'h0;
    logic        rsp_on = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    int          rsp_epoch = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        chk_live = 1'b0;
    logic        watch = 1'b0;
    logic [31:0] watch_pc = 32'h0;
    logic        found;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
    endfunction

    function automatic int live_cnt();
        int n = (rsp_on && rsp_epoch == epoch) ? 1 : 0;
        foreach (pending[i]) if (pending[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score outputs, model the memory, then advance past the edge
    task automatic cycle();
        logic        redir;
        logic [63:0] e;
        req_t        r;
        #1;
        redir = bus.redirect_valid_in;
        check("if_valid", 64'(bus.if_valid_out), 64'(expq.size() != 0));
        if (bus.if_valid_out && bus.if_ready_in && !redir && expq.size() != 0) begin
            e = expq.pop_front();
            check("if_pc", 64'(bus.if_pc_out), 64'(e[63:32]));
            check("if_instr", 64'(bus.if_instr_out), 64'(e[31:0]));
            if (watch) begin
                check("first_pc", 64'(bus.if_pc_out), 64'(watch_pc));
                watch = 1'b0;
            end
        end
        if (prev_stall && !redir) begin
            check("hold_valid", 64'(bus.imem_req_valid), 64'd1);
            check("hold_addr", 64'(bus.imem_req_addr), 64'(prev_addr));
        end
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready && !redir;
        prev_addr  = bus.imem_req_addr;
        if (redir) check("redir_noreq", 64'(bus.imem_req_valid), 64'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", 64'(bus.imem_req_addr), 64'(exp_fetch));
            pending.push_back('{bus.imem_req_addr, epoch, cyc + lat});
            exp_fetch += 32'd4;
        end
        if (rsp_on && rsp_epoch == epoch && !redir) expq.push_back({rsp_addr, word(rsp_addr)});
        if (redir) begin
            epoch++;
            expq.delete();
            exp_fetch = bus.redirect_pc_in & ~32'd3;
        end
        if (chk_live) check("live_bound", 64'(live_cnt() <= FIFO_DEPTH), 64'd1);
        @(posedge clk);
        cyc++;
        #1;
        rsp_on = pending.size() != 0 && pending[0].due <= cyc;
        if (rsp_on) begin
            r = pending.pop_front();
            rsp_addr  = r.addr;
            rsp_epoch = r.epoch;
        end
        bus.imem_rsp_valid = rsp_on;
        bus.imem_rsp_data  = rsp_on ? word(rsp_addr) : 32'h0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid_in = 1'b1;
        bus.redirect_pc_in    = target;
        watch    = 1'b1;
        watch_pc = target & ~32'd3;
        cycle();
        bus.redirect_valid_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = 32'h0;
        bus.imem_req_ready    = 1'b1;
        bus.imem_rsp_valid    = 1'b0;
        bus.imem_rsp_data     = 32'h0;
        bus.if_ready_in       = 1'b1;
        #12;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
        check("rst_if_valid", 64'(bus.if_valid_out), 64'd0);
        check("rst_if_pc", 64'(bus.if_pc_out), 64'h0);
        check("rst_if_instr", 64'(bus.if_instr_out), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming from reset with 1-cycle memory
        watch    = 1'b1;
        watch_pc = 32'h0;
        repeat (12) cycle();

        // Decode stalls: requests stop once the buffer budget is committed
        bus.if_ready_in = 1'b0;
        chk_live = 1'b1;
        repeat (10) cycle();
        #1;
        check("stall_req_low", 64'(bus.imem_req_valid), 64'd0);
        chk_live = 1'b0;
        bus.if_ready_in = 1'b1;
        repeat (10) cycle();

        // Memory backpressure toggling
        for (int i = 0; i < 16; i++) begin
            bus.imem_req_ready = i[0];
            cycle();
        end
        bus.imem_req_ready = 1'b1;
        repeat (6) cycle();

        // Redirect with two live requests in flight
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (live_cnt() >= 2) found = 1'b1;
            else cycle();
        end
        check("two_outstanding", 64'(found), 64'd1);
        redirect(32'h0000_0103);
        repeat (15) cycle();

        // Redirect coincident with a response and a pop, then wrap past 0xFFFF_FFFC
        lat = 1;
        redirect(32'hFFFF_FFF4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.imem_rsp_valid && bus.if_valid_out) found = 1'b1;
            else cycle();
        end
        check("coincident_seen", 64'(found), 64'd1);
        redirect(32'hFFFF_FFFC);
        repeat (14) cycle();

        // Reset mid-stream with three requests outstanding
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (live_cnt() >= 2) found = 1'b1;
            else cycle();
        end
        redirect(32'h0000_0040);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending.size() + (rsp_on ? 1 : 0) >= 3) found = 1'b1;
            else cycle();
        end
        check("three_outstanding", 64'(found), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("mid_rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
        check("mid_rst_if_valid", 64'(bus.if_valid_out), 64'd0);
        check("mid_rst_if_pc", 64'(bus.if_pc_out), 64'h0);
        check("mid_rst_if_instr", 64'(bus.if_instr_out), 64'h0);
        pending.delete();
        expq.delete();
        epoch++;
        exp_fetch  = 32'h0;
        prev_stall = 1'b0;
        rsp_on     = 1'b0;
        watch      = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        repeat (2) cycle();
        reset = 1'b0;
        lat = 1;
        watch    = 1'b1;
        watch_pc = 32'h0;
        repeat (12) cycle();
        check("watch_consumed", 64'(watch), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
